// File: rtl/uart_out_queue.sv
// Console output queue: buffers putch bytes and paces them onto the io_uart_out pins.
// Optional macro UART_OUT_CRLF_EN inserts 8'h0D ahead of every 8'h0A emitted.
module uart_out_queue #(
   parameter int DEPTH    = 16,
   parameter int CHAR_GAP = 3,
   parameter int CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_valid,
   input  logic [7:0]               push_ch,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     uart_out_valid,
   output logic [7:0]               uart_out_ch,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   state_t           state_q;
   logic             uart_out_valid_q;
   logic [7:0]       uart_out_ch_q;
   logic [GW-1:0]    gap_cnt_q;
`ifdef UART_OUT_CRLF_EN
   logic             crlf_done_q;
`endif

   logic             push_acc;
   logic             push_drop;
   logic             pop;
   logic             insert_cr;
   logic [7:0]       head_ch;

   assign full           = (count_q == CW'(DEPTH));
   assign empty          = (count_q == '0);
   assign count          = count_q;
   assign drop_cnt       = drop_cnt_q;
   assign uart_out_valid = uart_out_valid_q;
   assign uart_out_ch    = uart_out_ch_q;

   always_comb begin
      push_acc  = push_valid && !full;
      push_drop = push_valid && full;
      head_ch   = mem_q[rd_ptr_q];
`ifdef UART_OUT_CRLF_EN
      // The CR is emitted from IDLE without consuming the LF at the head.
      insert_cr = (head_ch == 8'h0A) && !crlf_done_q;
`else
      insert_cr = 1'b0;
`endif
      pop       = (state_q == IDLE) && !empty && !insert_cr;

      wr_ptr_d  = wr_ptr_q + AW'(push_acc);
      rd_ptr_d  = rd_ptr_q + AW'(pop);
      count_d   = count_q + CW'(push_acc) - CW'(pop);

      drop_cnt_d = drop_cnt_q;
      if (push_drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   // Storage is deliberately left unreset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_q[wr_ptr_q] <= push_ch;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // The strobe is registered from SEND, so it appears one cycle after the state enters SEND.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q          <= IDLE;
         uart_out_valid_q <= 1'b0;
         uart_out_ch_q    <= 8'h00;
         gap_cnt_q        <= '0;
`ifdef UART_OUT_CRLF_EN
         crlf_done_q      <= 1'b0;
`endif
      end else begin
         uart_out_valid_q <= (state_q == SEND);
         case (state_q)
            IDLE: begin
               if (!empty) begin
                  state_q <= SEND;
                  if (insert_cr) begin
                     uart_out_ch_q <= 8'h0D;
`ifdef UART_OUT_CRLF_EN
                     crlf_done_q   <= 1'b1;
`endif
                  end else begin
                     uart_out_ch_q <= head_ch;
`ifdef UART_OUT_CRLF_EN
                     crlf_done_q   <= 1'b0;
`endif
                  end
               end
            end
            SEND: begin
               if (CHAR_GAP > 0) begin
                  state_q   <= GAP;
                  gap_cnt_q <= GW'(CHAR_GAP - 1);
               end else begin
                  state_q   <= IDLE;
               end
            end
            GAP: begin
               if (gap_cnt_q == '0) begin
                  state_q   <= IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_out_queue.sv
// Directed bench for uart_out_queue (DEPTH=16, CHAR_GAP=3); honours UART_OUT_CRLF_EN if defined.
module tb_uart_out_queue;

   localparam int DEPTH    = 16;
   localparam int CHAR_GAP = 3;
   localparam int CNT_W    = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              push_valid = 1'b0;
   logic [7:0]        push_ch = 8'h00;
   logic              full;
   logic              empty;
   logic [4:0]        count;
   logic              uart_out_valid;
   logic [7:0]        uart_out_ch;
   logic [CNT_W-1:0]  drop_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int b2b = 0;
   logic prev_valid = 1'b0;
   int strobe_cyc[$];
   logic [7:0] strobe_ch[$];

   uart_out_queue #(.DEPTH(DEPTH), .CHAR_GAP(CHAR_GAP), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .push_valid     (push_valid),
      .push_ch        (push_ch),
      .full           (full),
      .empty          (empty),
      .count          (count),
      .uart_out_valid (uart_out_valid),
      .uart_out_ch    (uart_out_ch),
      .drop_cnt       (drop_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Records every strobe with the index of the posedge that preceded it.
   always @(negedge clk) begin
      if (uart_out_valid === 1'b1) begin
         strobe_cyc.push_back(cyc);
         strobe_ch.push_back(uart_out_ch);
         $display("strobe cyc=%0d ch=%h", cyc, uart_out_ch);
         if (prev_valid) b2b++;
      end
      prev_valid = (uart_out_valid === 1'b1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] b);
      push_valid = 1'b1;
      push_ch    = b;
      tick(1);
      push_valid = 1'b0;
   endtask

   task automatic clear_mon();
      strobe_cyc.delete();
      strobe_ch.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(3);
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
      checks++; if (uart_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", uart_out_valid); end
      checks++; if (uart_out_ch !== 8'h00) begin errors++; $display("FAIL reset_ch got %h want 00", uart_out_ch); end
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
      rst = 1'b1;
      tick(2);
   endtask

   task automatic test_single();
      int n;
      clear_mon();
      push(8'h48);
      n = cyc;
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count_after_push got %0d want 1", count); end
      tick(12);
      checks++; if (strobe_ch.size() !== 1) begin errors++; $display("FAIL single_nstrobes got %0d want 1", strobe_ch.size()); end
      if (strobe_ch.size() > 0) begin
         checks++; if (strobe_ch[0] !== 8'h48) begin errors++; $display("FAIL single_ch got %h want 48", strobe_ch[0]); end
         checks++; if (strobe_cyc[0] !== n + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", strobe_cyc[0], n + 2); end
      end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count_end got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_end got %b want 1", empty); end
   endtask

   task automatic test_abc();
      int n;
      logic [7:0] want;
      clear_mon();
      push(8'h41);
      n = cyc;
      push(8'h42);
      push(8'h43);
      tick(20);
      checks++; if (strobe_ch.size() !== 3) begin errors++; $display("FAIL abc_nstrobes got %0d want 3", strobe_ch.size()); end
      for (int i = 0; i < 3; i++) begin
         want = 8'h41 + 8'(i);
         checks++;
         if (i >= strobe_ch.size()) begin
            errors++; $display("FAIL abc_missing idx %0d want %h", i, want);
         end else begin
            if (strobe_ch[i] !== want || strobe_cyc[i] !== n + 2 + 5 * i) begin
               errors++;
               $display("FAIL abc_strobe idx %0d got %h@%0d want %h@%0d", i, strobe_ch[i], strobe_cyc[i], want, n + 2 + 5 * i);
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] expq[$];
      logic [7:0] got;
      for (int i = 0; i < 20; i++) expq.push_back(8'h60 + 8'(i));
      expq.push_back(8'h76);
      clear_mon();
      for (int i = 0; i < 24; i++) begin
         push(8'h60 + 8'(i));
         if (i == 19) begin
            checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count_full got %0d want 16", count); end
            checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", full); end
         end
      end
      tick(130);
      checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL ovf_drop got %0d want 3", drop_cnt); end
      checks++; if (strobe_ch.size() !== expq.size()) begin errors++; $display("FAIL ovf_nstrobes got %0d want %0d", strobe_ch.size(), expq.size()); end
      for (int i = 0; i < expq.size(); i++) begin
         got = (i < strobe_ch.size()) ? strobe_ch[i] : 8'hxx;
         checks++; if (got !== expq[i]) begin errors++; $display("FAIL ovf_order idx %0d got %h want %h", i, got, expq[i]); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty_end got %b want 1", empty); end
   endtask

   task automatic test_pop_while_full();
      logic [7:0] got;
      int found;
      clear_mon();
      for (int i = 0; i < 20; i++) push(8'h30 + 8'(i));
      tick(1);
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL pwf_count_pre got %0d want 16", count); end
      push(8'h5A);
      checks++; if (count !== 5'd15) begin errors++; $display("FAIL pwf_count_post got %0d want 15", count); end
      checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL pwf_drop got %0d want 4", drop_cnt); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL pwf_full_post got %b want 0", full); end
      tick(120);
      checks++; if (strobe_ch.size() !== 20) begin errors++; $display("FAIL pwf_nstrobes got %0d want 20", strobe_ch.size()); end
      found = 0;
      for (int i = 0; i < 20; i++) begin
         got = (i < strobe_ch.size()) ? strobe_ch[i] : 8'hxx;
         if (got === 8'h5A) found++;
         checks++; if (got !== 8'h30 + 8'(i)) begin errors++; $display("FAIL pwf_order idx %0d got %h want %h", i, got, 8'h30 + 8'(i)); end
      end
      checks++; if (found !== 0) begin errors++; $display("FAIL pwf_5a_emitted got %0d want 0", found); end
   endtask

   task automatic test_reset_mid();
      int n;
      clear_mon();
      push(8'h21);
      n = cyc;
      for (int i = 1; i < 7; i++) push(8'h21 + 8'(i));
      tick(1);
      checks++; if (count !== 5'd5) begin errors++; $display("FAIL rmid_count_pre got %0d want 5", count); end
      rst = 1'b0;
      tick(1);
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got %b want 1", empty); end
      checks++; if (uart_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", uart_out_valid); end
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rmid_drop got %0d want 0", drop_cnt); end
      rst = 1'b1;
      tick(30);
      checks++; if (strobe_ch.size() !== 2) begin errors++; $display("FAIL rmid_nstrobes got %0d want 2", strobe_ch.size()); end
      if (strobe_ch.size() >= 2) begin
         checks++; if (strobe_ch[1] !== 8'h22 || strobe_cyc[1] !== n + 7) begin errors++; $display("FAIL rmid_last got %h@%0d want 22@%0d", strobe_ch[1], strobe_cyc[1], n + 7); end
      end
   endtask

   task automatic test_crlf();
      int n;
      clear_mon();
      push(8'h0A);
      n = cyc;
      tick(1);
`ifdef UART_OUT_CRLF_EN
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL crlf_count_cr got %0d want 1", count); end
      tick(15);
      checks++; if (strobe_ch.size() !== 2) begin errors++; $display("FAIL crlf_nstrobes got %0d want 2", strobe_ch.size()); end
      if (strobe_ch.size() >= 2) begin
         checks++; if (strobe_ch[0] !== 8'h0D || strobe_cyc[0] !== n + 2) begin errors++; $display("FAIL crlf_cr got %h@%0d want 0d@%0d", strobe_ch[0], strobe_cyc[0], n + 2); end
         checks++; if (strobe_ch[1] !== 8'h0A || strobe_cyc[1] !== n + 7) begin errors++; $display("FAIL crlf_lf got %h@%0d want 0a@%0d", strobe_ch[1], strobe_cyc[1], n + 7); end
      end
`else
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL lf_count_pop got %0d want 0", count); end
      tick(15);
      checks++; if (strobe_ch.size() !== 1) begin errors++; $display("FAIL lf_nstrobes got %0d want 1", strobe_ch.size()); end
      if (strobe_ch.size() >= 1) begin
         checks++; if (strobe_ch[0] !== 8'h0A || strobe_cyc[0] !== n + 2) begin errors++; $display("FAIL lf_strobe got %h@%0d want 0a@%0d", strobe_ch[0], strobe_cyc[0], n + 2); end
      end
`endif
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL crlf_empty_end got %b want 1", empty); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_abc();
      test_overflow();
      test_pop_while_full();
      test_reset_mid();
      test_crlf();
      checks++; if (b2b !== 0) begin errors++; $display("FAIL strobe_b2b got %0d want 0", b2b); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
